note_step_sequencer: RTL and testbench

- Reads the 64-bit note grid produced by the red-block detector and plays it as an 8-step sequencer.
- Grid layout: bit index = row*8 + col, where row is the vertical block and col is the horizontal block.
- Steps through columns 0..7 at a fixed step period and emits one note event per set row over a valid/ready handshake to the downstream tone synthesizer.
- Sits between the detector output and the audio path.

---
 rtl/note_seq_pkg.sv | 29 ++
 rtl/note_row_picker.sv | 20 ++
 rtl/note_step_sequencer.sv | 153 +++++++++++++++
 tb/tb_note_step_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared types and grid helpers for the 8x8 note step sequencer.
// A grid bit is addressed as row*8 + col.
package note_seq_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    HOLD = 2'd3
  } seq_state_e;

  function automatic logic [5:0] note_bit(input logic [2:0] row, input logic [2:0] col);
    return (6'(row) * 6'd8) + 6'(col);
  endfunction

  // Bit r of the result is grid[row r, column col].
  function automatic logic [7:0] column_mask(input logic [63:0] grid, input logic [2:0] col);
    logic [7:0] mask;
    mask = 8'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      mask[r] = grid[note_bit(3'(r), col)];
    end
    return mask;
  endfunction

endpackage

// File: rtl/note_row_picker.sv
// Lowest-set-bit encoder over an 8-bit row mask; also flags when exactly
// one bit is set so the caller can mark the final event of a step.
module note_row_picker (
  input  logic [7:0] mask,
  output logic [2:0] row,
  output logic       any,
  output logic       single_left
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    row = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      row = mask[i] ? 3'(i) : row;
    end
    any         = |mask;
    single_left = any && ((mask & (mask - 8'd1)) == 8'd0);
  end

endmodule

// File: rtl/note_step_sequencer.sv
// Plays the detector's 64-bit note grid as an 8-step sequencer, emitting one
// valid/ready event per set row of the current column.
module note_step_sequencer
  import note_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 3125000,
  parameter int TIMER_W     = 24
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [63:0] iNote,
  input  logic        iEnable,
  input  logic        iEvt_ready,
  output logic        oEvt_valid,
  output logic [2:0]  oEvt_row,
  output logic        oEvt_last,
  output logic [2:0]  oStep,
  output logic [7:0]  oColumn,
  output logic        oBar,
  output logic        oOverrun
);

  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(STEP_CYCLES - 1);

  seq_state_e         state_r, state_nxt_s;
  logic [TIMER_W-1:0] timer_r, timer_nxt_s, timer_inc_s;
  logic [2:0]         column_r, column_nxt_s;
  logic [63:0]        snapshot_r, snapshot_nxt_s;
  logic [7:0]         pending_r, pending_nxt_s;
  logic [7:0]         load_mask_s, accept_mask_s, pending_left_s;
  logic [2:0]         pick_row_s;
  logic               pick_any_s, pick_single_s;
  logic               valid_s, fire_s, expire_s, overrun_s;

  note_row_picker u_picker (
    .mask        (pending_r),
    .row         (pick_row_s),
    .any         (pick_any_s),
    .single_left (pick_single_s)
  );

  // Handshake, timer and column-mask helpers shared by the FSM and outputs.
  always_comb begin
    valid_s        = (state_r == EMIT) && pick_any_s;
    fire_s         = valid_s && iEvt_ready;
    expire_s       = (timer_r == LAST_TICK);
    timer_inc_s    = expire_s ? '0 : (timer_r + TIMER_W'(1));
    accept_mask_s  = fire_s ? (8'd1 << pick_row_s) : 8'd0;
    pending_left_s = pending_r & ~accept_mask_s;
    // Column 0 reads the grid directly so bar 0 plays what is being captured.
    load_mask_s    = column_mask((column_r == 3'd0) ? iNote : snapshot_r, column_r);
  end

  // Next-state logic for the step FSM.
  always_comb begin
    state_nxt_s    = state_r;
    timer_nxt_s    = timer_r;
    column_nxt_s   = column_r;
    snapshot_nxt_s = snapshot_r;
    pending_nxt_s  = pending_r;
    overrun_s      = 1'b0;
    if (!iEnable) begin
      state_nxt_s   = IDLE;
      timer_nxt_s   = '0;
      column_nxt_s  = 3'd0;
      pending_nxt_s = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s   = LOAD;
          timer_nxt_s   = '0;
          column_nxt_s  = 3'd0;
          pending_nxt_s = 8'd0;
        end
        LOAD: begin
          if (column_r == 3'd0) begin
            snapshot_nxt_s = iNote;
          end else begin
            snapshot_nxt_s = snapshot_r;
          end
          pending_nxt_s = load_mask_s;
          timer_nxt_s   = timer_inc_s;
          state_nxt_s   = (load_mask_s != 8'd0) ? EMIT : HOLD;
        end
        EMIT: begin
          timer_nxt_s   = timer_inc_s;
          pending_nxt_s = pending_left_s;
          if (expire_s) begin
            // A handshake in the expiry cycle still counts; anything left is lost.
            overrun_s     = (pending_left_s != 8'd0);
            pending_nxt_s = 8'd0;
            column_nxt_s  = column_r + 3'd1;
            state_nxt_s   = LOAD;
          end else if (pending_left_s == 8'd0) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = EMIT;
          end
        end
        HOLD: begin
          timer_nxt_s = timer_inc_s;
          if (expire_s) begin
            column_nxt_s = column_r + 3'd1;
            state_nxt_s  = LOAD;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          timer_nxt_s   = '0;
          column_nxt_s  = 3'd0;
          pending_nxt_s = 8'd0;
        end
      endcase
    end
  end

  // State, timer, column, snapshot and pending-row registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r    <= IDLE;
      timer_r    <= '0;
      column_r   <= 3'd0;
      snapshot_r <= 64'd0;
      pending_r  <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      timer_r    <= timer_nxt_s;
      column_r   <= column_nxt_s;
      snapshot_r <= snapshot_nxt_s;
      pending_r  <= pending_nxt_s;
    end
  end

  // Output decode; event fields are held at zero whenever no event is offered.
  always_comb begin
    oEvt_valid = valid_s;
    oEvt_row   = valid_s ? pick_row_s : 3'd0;
    oEvt_last  = valid_s && pick_single_s;
    oStep      = column_r;
    oBar       = (state_r == LOAD) && (column_r == 3'd0);
    oOverrun   = overrun_s;
    if (state_r == IDLE) begin
      oColumn = 8'd0;
    end else if (state_r == LOAD) begin
      oColumn = load_mask_s;
    end else begin
      oColumn = column_mask(snapshot_r, column_r);
    end
  end

endmodule

// File: tb/tb_note_step_sequencer.sv
// Randomized and directed bench for note_step_sequencer with STEP_CYCLES=16,
// checked cycle by cycle against a step-position reference model.
module tb_note_step_sequencer;

  localparam int SC = 16;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [63:0] iNote;
  logic        iEnable;
  logic        iEvt_ready;
  logic        oEvt_valid;
  logic [2:0]  oEvt_row;
  logic        oEvt_last;
  logic [2:0]  oStep;
  logic [7:0]  oColumn;
  logic        oBar;
  logic        oOverrun;

  always #5 iCLK = ~iCLK;

  note_step_sequencer #(.STEP_CYCLES(SC), .TIMER_W(24)) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iNote      (iNote),
    .iEnable    (iEnable),
    .iEvt_ready (iEvt_ready),
    .oEvt_valid (oEvt_valid),
    .oEvt_row   (oEvt_row),
    .oEvt_last  (oEvt_last),
    .oStep      (oStep),
    .oColumn    (oColumn),
    .oBar       (oBar),
    .oOverrun   (oOverrun)
  );

  // Reference model: idle flag, position inside the step (0 = load cycle),
  // current column, bar snapshot and the ordered list of rows still to play.
  bit          m_idle;
  int          m_pos;
  int          m_col;
  logic [63:0] m_snap;
  int          q[$];

  int cyc;
  int pass_n;
  int total_n;
  bit rand_ready;
  int fire_cyc[$];
  int fire_row[$];
  int fire_last[$];
  int bar_cyc[$];
  int ovr_cyc[$];

  function automatic logic [7:0] colmask(input logic [63:0] g, input int c);
    logic [7:0] m;
    for (int r = 0; r < 8; r++) m[r] = g[r*8 + c];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic compare();
    logic       e_valid, e_last, e_bar, e_ovr;
    logic [2:0] e_row, e_step;
    logic [7:0] e_col;
    int         left;
    e_valid = 1'b0; e_last = 1'b0; e_bar = 1'b0; e_ovr = 1'b0;
    e_row = 3'd0; e_step = 3'd0; e_col = 8'd0;
    if (iRST_N && !m_idle) begin
      e_step = 3'(m_col);
      if (m_pos == 0) begin
        e_bar = (m_col == 0);
        e_col = colmask((m_col == 0) ? iNote : m_snap, m_col);
      end else begin
        e_col   = colmask(m_snap, m_col);
        e_valid = (q.size() > 0);
        if (e_valid) begin
          e_row  = 3'(q[0]);
          e_last = (q.size() == 1);
        end
        left  = q.size() - ((e_valid && iEvt_ready) ? 1 : 0);
        e_ovr = iEnable && (m_pos == SC - 1) && (left > 0);
      end
    end
    chk("valid", 64'(oEvt_valid), 64'(e_valid));
    if (e_valid || m_idle || !iRST_N) begin
      chk("row", 64'(oEvt_row), 64'(e_row));
      chk("last", 64'(oEvt_last), 64'(e_last));
    end
    chk("step", 64'(oStep), 64'(e_step));
    chk("column", 64'(oColumn), 64'(e_col));
    chk("bar", 64'(oBar), 64'(e_bar));
    chk("overrun", 64'(oOverrun), 64'(e_ovr));
    if (oEvt_valid && iEvt_ready) begin
      fire_cyc.push_back(cyc);
      fire_row.push_back(int'(oEvt_row));
      fire_last.push_back(int'(oEvt_last));
    end
    if (oBar) bar_cyc.push_back(cyc);
    if (oOverrun) ovr_cyc.push_back(cyc);
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_pos = 0; m_col = 0; m_snap = 64'd0; q.delete();
  endtask

  task automatic model_step();
    if (!iRST_N) begin
      model_reset();
    end else if (!iEnable || m_idle) begin
      m_idle = !iEnable; m_pos = 0; m_col = 0; q.delete();
    end else begin
      if (m_pos == 0) begin
        if (m_col == 0) m_snap = iNote;
        q.delete();
        for (int r = 0; r < 8; r++) if (m_snap[r*8 + m_col]) q.push_back(r);
      end else if (q.size() > 0 && iEvt_ready) begin
        void'(q.pop_front());
      end
      if (m_pos == SC - 1) begin
        m_pos = 0; m_col = (m_col + 1) % 8; q.delete();
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic tick();
    @(negedge iCLK);
    compare();
    @(posedge iCLK);
    model_step();
    cyc++;
    #1;
    if (rand_ready) iEvt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    fire_cyc.delete(); fire_row.delete(); fire_last.delete();
    bar_cyc.delete(); ovr_cyc.delete();
  endtask

  initial begin
    int          start;
    logic [63:0] g;
    int          exp_rows[10];
    pass_n = 0; total_n = 0; cyc = 0; rand_ready = 1'b0;
    model_reset();
    iRST_N = 1'b0; iEnable = 1'b0; iEvt_ready = 1'b0; iNote = 64'd0;
    ticks(3);
    chk("reset_step", 64'(oStep), 64'd0);
    chk("reset_valid", 64'(oEvt_valid), 64'd0);
    iRST_N = 1'b1;
    ticks(2);

    // Diagonal grid: one event per step, rows follow the column.
    g = 64'd0;
    for (int c = 0; c < 8; c++) g[c*9] = 1'b1;
    iNote = g; iEvt_ready = 1'b1; clear_logs();
    start = cyc; iEnable = 1'b1;
    ticks(130);
    chk("diag_nfires", 64'(fire_cyc.size()), 64'd8);
    chk("diag_nbars", 64'(bar_cyc.size()), 64'd2);
    if (fire_cyc.size() == 8 && bar_cyc.size() == 2) begin
      chk("diag_bar0", 64'(bar_cyc[0] - start), 64'd1);
      chk("diag_bar_period", 64'(bar_cyc[1] - bar_cyc[0]), 64'd128);
      chk("diag_first_lat", 64'(fire_cyc[0] - bar_cyc[0]), 64'd1);
      for (int i = 0; i < 8; i++) begin
        chk("diag_row", 64'(fire_row[i]), 64'(i));
        chk("diag_last", 64'(fire_last[i]), 64'd1);
        chk("diag_gap", 64'(fire_cyc[i] - fire_cyc[0]), 64'(16 * i));
      end
    end
    iEnable = 1'b0; ticks(2);

    // Column 0 full: eight back-to-back events, last only on row 7.
    iNote = 64'h0101010101010101; clear_logs();
    iEnable = 1'b1;
    ticks(20);
    chk("full_nfires", 64'(fire_cyc.size()), 64'd8);
    chk("full_novr", 64'(ovr_cyc.size()), 64'd0);
    if (fire_cyc.size() == 8 && bar_cyc.size() >= 1) begin
      for (int k = 0; k < 8; k++) begin
        chk("full_cyc", 64'(fire_cyc[k] - bar_cyc[0]), 64'(k + 1));
        chk("full_row", 64'(fire_row[k]), 64'(k));
        chk("full_last", 64'(fire_last[k]), 64'(k == 7));
      end
    end
    iEnable = 1'b0; ticks(2);

    // Same grid with ready held low: row 0 stalls, overrun at expiry.
    iEvt_ready = 1'b0; clear_logs();
    iEnable = 1'b1;
    ticks(20);
    chk("stall_nfires", 64'(fire_cyc.size()), 64'd0);
    chk("stall_novr", 64'(ovr_cyc.size()), 64'd1);
    if (ovr_cyc.size() == 1 && bar_cyc.size() >= 1)
      chk("stall_ovr_pos", 64'(ovr_cyc[0] - bar_cyc[0]), 64'd15);
    iEnable = 1'b0; ticks(2);

    // Grid change at step 3 only shows up from the next bar.
    iEvt_ready = 1'b1; iNote = g; clear_logs();
    iEnable = 1'b1;
    ticks(49);
    for (int c = 0; c < 8; c++) begin
      iNote[c*9] = 1'b0;
      iNote[(7 - c)*8 + c] = 1'b1;
    end
    ticks(100);
    exp_rows = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6};
    chk("chg_nfires", 64'(fire_row.size()), 64'd10);
    if (fire_row.size() == 10)
      for (int i = 0; i < 10; i++) chk("chg_row", 64'(fire_row[i]), 64'(exp_rows[i]));
    iEnable = 1'b0; ticks(2);

    // Empty grid: steps advance, nothing is emitted.
    iNote = 64'd0; clear_logs();
    iEnable = 1'b1;
    ticks(40);
    chk("empty_nfires", 64'(fire_cyc.size()), 64'd0);
    chk("empty_step", 64'(oStep), 64'd2);
    iEnable = 1'b0; ticks(2);

    // Drop enable while stalled in step 5, re-enable three cycles later.
    iNote = 64'h2020202020202020; iEvt_ready = 1'b0; clear_logs();
    start = cyc; iEnable = 1'b1;
    ticks(84);
    chk("drop_pre_valid", 64'(oEvt_valid), 64'd1);
    iEnable = 1'b0;
    ticks(3);
    iEnable = 1'b1;
    ticks(4);
    chk("drop_novr", 64'(ovr_cyc.size()), 64'd0);
    chk("drop_nbars", 64'(bar_cyc.size()), 64'd2);
    if (bar_cyc.size() == 2) chk("drop_restart", 64'(bar_cyc[1] - start), 64'd88);

    // Randomized run: random grids, ready and occasional enable toggles.
    rand_ready = 1'b1;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0)
        iNote = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      if ($urandom_range(0, 149) == 0) iEnable = ~iEnable;
      tick();
    end
    rand_ready = 1'b0;

    // Asynchronous reset while an event is presented.
    iEnable = 1'b0; ticks(2);
    iNote = 64'h0101010101010101; iEvt_ready = 1'b0; iEnable = 1'b1;
    ticks(4);
    chk("pre_rst_valid", 64'(oEvt_valid), 64'd1);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("async_rst_valid", 64'(oEvt_valid), 64'd0);
    model_reset();
    ticks(2);
    iRST_N = 1'b1;
    iEvt_ready = 1'b1;
    ticks(20);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
